// File: rtl/alu_seq.sv
// Sequencer that drives an external 8-bit ALU through IDLE/EXEC/DONE and captures its result.
// Latency: done two cycles after acceptance for ADD/SUB/SHL/SHR, plus MULDIV_WAIT cycles for MUL/DIV;
// faulting requests report done one cycle after acceptance. Backpressure: none; req is only
// sampled in IDLE, so requests arriving while busy are dropped.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   req, op, src_sel  operation request, opcode, first-operand source (0 = DinA)
//   divisor           ALU second operand, inspected only for the DIV zero check
//   alu_dout          ALU result bus, captured on the edge that ends EXEC
//   ISUMn..ISHRn, An  active-low ALU op selects and operand select
//   busy, done        in-flight flag and one-cycle completion pulse
//   result, zero, err captured result, zero flag, fault flag (held until next completion)
module alu_seq #(
  parameter int MULDIV_WAIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [2:0] op,
  input  logic       src_sel,
  input  logic [7:0] divisor,
  input  logic [7:0] alu_dout,
  output logic       ISUMn,
  output logic       ISUBn,
  output logic       IMULn,
  output logic       IDIVn,
  output logic       ISHLn,
  output logic       ISHRn,
  output logic       An,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       zero,
  output logic       err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;

  state_t     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic       src_q, src_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] sel_q, sel_d;      // bit index equals opcode: {SHR,SHL,DIV,MUL,SUB,SUM}
  logic       an_q, an_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] result_q, result_d;
  logic       zero_q, zero_d;
  logic       err_q, err_d;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    src_d    = src_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          op_d  = op;
          src_d = src_sel;
          if (op[2] && op[1]) begin
            // Illegal opcode: report the fault, leave result/zero alone.
            state_d = S_DONE;
            err_d   = 1'b1;
          end else if (op == OP_DIV && divisor == 8'h00) begin
            state_d  = S_DONE;
            err_d    = 1'b1;
            result_d = 8'hFF;
            zero_d   = 1'b0;
          end else begin
            state_d = S_EXEC;
            // Counter holds the number of EXEC cycles remaining after the current one.
            cnt_d   = (op == OP_MUL || op == OP_DIV) ? 4'(MULDIV_WAIT) : 4'd0;
          end
        end
      end
      S_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_DONE;
          result_d = alu_dout;
          zero_d   = (alu_dout == 8'h00);
          err_d    = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    sel_d  = (state_d == S_EXEC) ? (6'h3F & ~(6'd1 << op_d)) : 6'h3F;
    an_d   = (state_d == S_EXEC) ? src_d : 1'b1;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      src_q    <= 1'b0;
      cnt_q    <= 4'd0;
      sel_q    <= 6'h3F;
      an_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 8'h00;
      zero_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      src_q    <= src_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      an_q     <= an_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  assign ISUMn  = sel_q[0];
  assign ISUBn  = sel_q[1];
  assign IMULn  = sel_q[2];
  assign IDIVn  = sel_q[3];
  assign ISHLn  = sel_q[4];
  assign ISHRn  = sel_q[5];
  assign An     = an_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign zero   = zero_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Testbench for alu_seq: directed and randomized operations against a transaction-level model.
// Latency: each operation is followed cycle by cycle from acceptance to the idle cycle after done.
// Backpressure: request inputs are scrambled while busy to confirm they are ignored.
module tb_alu_seq;

  localparam int W = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic [2:0] op;
  logic       src_sel;
  logic [7:0] divisor;
  logic [7:0] alu_dout;
  logic       ISUMn, ISUBn, IMULn, IDIVn, ISHLn, ISHRn;
  logic       An, busy, done, zero, err;
  logic [7:0] result;

  int tests  = 0;
  int failed = 0;

  // Reference state: what result/zero/err must read after the latest completion.
  logic [7:0] m_result;
  logic       m_zero;
  logic       m_err;

  always #5 clk = ~clk;

  alu_seq #(.MULDIV_WAIT(W)) dut (
    .clk(clk), .rst(rst), .req(req), .op(op), .src_sel(src_sel),
    .divisor(divisor), .alu_dout(alu_dout),
    .ISUMn(ISUMn), .ISUBn(ISUBn), .IMULn(IMULn), .IDIVn(IDIVn),
    .ISHLn(ISHLn), .ISHRn(ISHRn), .An(An), .busy(busy), .done(done),
    .result(result), .zero(zero), .err(err)
  );

  wire [5:0] sel_obs = {ISHRn, ISHLn, IDIVn, IMULn, ISUBn, ISUMn};

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request from IDLE and follow it to the idle cycle after done.
  // forced < 0 drives random ALU data each EXEC cycle; keep_req holds req high
  // and switches op to next_op right after acceptance.
  task automatic run_op(input logic [2:0] o, input logic s, input logic [7:0] dv,
                        input int forced, input bit keep_req, input logic [2:0] next_op);
    bit         illegal, divz;
    int         len;
    logic [7:0] last;
    logic [5:0] exp_sel;
    illegal = (o >= 3'd6);
    divz    = (o == 3'd3) && (dv == 8'h00);
    len     = (illegal || divz) ? 0 : ((o == 3'd2 || o == 3'd3) ? 1 + W : 1);
    exp_sel = illegal ? 6'h3F : (6'h3F & ~(6'd1 << o));
    last    = 8'h00;

    req = 1'b1; op = o; src_sel = s; divisor = dv; alu_dout = 8'($urandom);
    step();
    req     = keep_req;
    op      = keep_req ? next_op : 3'($urandom);
    src_sel = 1'($urandom);
    divisor = 8'($urandom);

    for (int k = 0; k < len; k++) begin
      chk("exec_sel", {2'b00, sel_obs}, {2'b00, exp_sel});
      chk("exec_An", {7'd0, An}, {7'd0, s});
      chk("exec_busy", {7'd0, busy}, 8'd1);
      chk("exec_done", {7'd0, done}, 8'd0);
      alu_dout = (forced >= 0) ? 8'(forced) : 8'($urandom);
      last     = alu_dout;
      step();
    end

    if (illegal) begin
      m_err = 1'b1;
    end else if (divz) begin
      m_err = 1'b1; m_result = 8'hFF; m_zero = 1'b0;
    end else begin
      m_err = 1'b0; m_result = last; m_zero = (last == 8'h00);
    end

    chk("done_pulse", {7'd0, done}, 8'd1);
    chk("done_busy", {7'd0, busy}, 8'd1);
    chk("done_sel", {2'b00, sel_obs}, 8'h3F);
    chk("done_An", {7'd0, An}, 8'd1);
    chk("result", result, m_result);
    chk("zero", {7'd0, zero}, {7'd0, m_zero});
    chk("err", {7'd0, err}, {7'd0, m_err});
    step();
    chk("idle_done", {7'd0, done}, 8'd0);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_result", result, m_result);
    chk("idle_err", {7'd0, err}, {7'd0, m_err});
  endtask

  initial begin
    rst = 1'b1; req = 1'b1; op = 3'd0; src_sel = 1'b0; divisor = 8'h01; alu_dout = 8'h00;
    m_result = 8'h00; m_zero = 1'b1; m_err = 1'b0;
    step();
    step();
    // Reset state, with req held high throughout reset.
    chk("rst_sel", {2'b00, sel_obs}, 8'h3F);
    chk("rst_An", {7'd0, An}, 8'd1);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_result", result, 8'h00);
    chk("rst_zero", {7'd0, zero}, 8'd1);
    chk("rst_err", {7'd0, err}, 8'd0);
    rst = 1'b0; req = 1'b0;
    step();
    chk("post_rst_busy", {7'd0, busy}, 8'd0);

    // Directed cases.
    run_op(3'd0, 1'b0, 8'h10, 8'h2A, 1'b0, 3'd0);   // ADD from DinA
    run_op(3'd2, 1'b1, 8'h03, 8'h00, 1'b0, 3'd0);   // MUL giving zero
    run_op(3'd3, 1'b0, 8'h00, -1, 1'b0, 3'd0);      // DIV by zero
    run_op(3'd0, 1'b1, 8'h01, 8'h55, 1'b0, 3'd0);   // ADD to set result 55
    run_op(3'd7, 1'b0, 8'h01, -1, 1'b0, 3'd0);      // illegal keeps 55
    run_op(3'd6, 1'b1, 8'h01, -1, 1'b0, 3'd0);      // other illegal opcode
    run_op(3'd3, 1'b1, 8'h07, -1, 1'b0, 3'd0);      // DIV nonzero divisor
    // req held high: SUB runs, op switches to SHL while busy, SHL follows at N+3.
    run_op(3'd1, 1'b0, 8'h01, -1, 1'b1, 3'd4);
    run_op(3'd4, 1'b1, 8'h01, -1, 1'b0, 3'd0);

    // Randomized operations.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      logic [7:0] rd;
      ro = 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      run_op(ro, 1'($urandom), rd, ($urandom_range(0, 7) == 0) ? 0 : -1, 1'b0, 3'd0);
    end

    // Reset during a SHR EXEC cycle aborts it with no done pulse.
    req = 1'b1; op = 3'd5; src_sel = 1'b1; divisor = 8'h01; alu_dout = 8'h99;
    step();
    req = 1'b0;
    chk("shr_exec_sel", {2'b00, sel_obs}, 8'h1F);
    rst = 1'b1; req = 1'b1;
    step();
    m_result = 8'h00; m_zero = 1'b1; m_err = 1'b0;
    chk("abort_sel", {2'b00, sel_obs}, 8'h3F);
    chk("abort_done", {7'd0, done}, 8'd0);
    chk("abort_busy", {7'd0, busy}, 8'd0);
    chk("abort_result", result, m_result);
    chk("abort_zero", {7'd0, zero}, {7'd0, m_zero});
    // req was high at the reset edge; it must not have been accepted.
    rst = 1'b0; req = 1'b0;
    step();
    chk("rst_req_ignored", {7'd0, busy}, 8'd0);
    chk("rst_req_no_done", {7'd0, done}, 8'd0);
    run_op(3'd0, 1'b0, 8'h01, 8'h81, 1'b0, 3'd0);   // still operational after abort

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
